// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pc_ctrl_pkg : action priority encoding and reset-vector default for pc_ctrl
// Revision    : 1.0
// ============================================================================
package pc_ctrl_pkg;

    // Every bit of the default reset vector takes this value, so the default is all ones at any width
    localparam logic DEFAULT_RESET_BIT = 1'b1;

    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_ENABLE = 3'd1,
        ACT_BRANCH = 3'd2,
        ACT_RET    = 3'd3,
        ACT_CALL   = 3'd4,
        ACT_LOAD   = 3'd5
    } action_e;

    // Priority order: load > call > ret > branch > enable
    function automatic action_e pick_action(
        input logic load,
        input logic call,
        input logic ret,
        input logic branch,
        input logic enable
    );
        action_e act;
        if (load)        act = ACT_LOAD;
        else if (call)   act = ACT_CALL;
        else if (ret)    act = ACT_RET;
        else if (branch) act = ACT_BRANCH;
        else if (enable) act = ACT_ENABLE;
        else             act = ACT_HOLD;
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// pc_ret_stack : LIFO of return addresses, unreset storage, reset level
// Revision     : 1.0
// ============================================================================
module pc_ret_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    // Slot count is rounded up to a power of two so the index width matches exactly
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [LVL_W-1:0] r_level;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_push;
    logic             w_pop;

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_push    = push & ~full;
    assign w_pop     = pop & ~empty & ~push;
    assign w_wr_idx  = IDX_W'(r_level);
    assign w_top_idx = IDX_W'(r_level - LVL_W'(1));
    assign top_data  = empty ? '0 : mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else if (w_push) begin
            r_level <= r_level + LVL_W'(1);
        end else if (w_pop) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// pc_ctrl  : program counter with jump/branch and optional return stack
//            (return stack built only when PC_CTRL_STACK_EN is defined)
// Revision : 1.0
// ============================================================================
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  int               DEPTH     = 4,
    parameter  logic [WIDTH-1:0] RESET_VEC = {WIDTH{DEFAULT_RESET_BIT}},
    localparam int               SP_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] nxt_adr,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] crnt_adr,
    output logic [SP_W-1:0]  sp_level,
    output logic             overflow,
    output logic             underflow
);

    action_e          w_action;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] r_pc;

    assign crnt_adr = r_pc;

`ifdef PC_CTRL_STACK_EN
    logic w_full;
    logic w_empty;
    logic r_overflow;
    logic r_underflow;

    assign w_action = pick_action(load, call, ret, branch, enable);
    assign w_push   = (w_action == ACT_CALL) && !w_full;
    assign w_pop    = (w_action == ACT_RET) && !w_empty;

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_pc + WIDTH'(1)),
        .top_data  (w_top),
        .level     (sp_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Later assignments override the clear, so a coincident error event keeps its flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if ((w_action == ACT_CALL) && w_full) begin
                r_overflow <= 1'b1;
            end
            if ((w_action == ACT_RET) && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic unused_inputs;

    // Without a stack, call degrades to load and ret drops out of the priority chain
    assign w_action      = pick_action(load | call, 1'b0, 1'b0, branch, enable);
    assign w_push        = 1'b0;
    assign w_pop         = 1'b0;
    assign w_top         = '0;
    assign sp_level      = '0;
    assign overflow      = 1'b0;
    assign underflow     = 1'b0;
    assign unused_inputs = &{1'b0, ret, clr_err};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_VEC;
        end else begin
            case (w_action)
                ACT_LOAD:   r_pc <= nxt_adr;
                ACT_CALL:   if (w_push) r_pc <= nxt_adr;
                ACT_RET:    if (w_pop) r_pc <= w_top;
                ACT_BRANCH: r_pc <= r_pc + offset;
                ACT_ENABLE: r_pc <= r_pc + WIDTH'(1);
                default:    r_pc <= r_pc;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_ctrl : directed and randomized checks of pc_ctrl against a queue model
// Revision   : 1.0
// ============================================================================
module tb_pc_ctrl;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 2;
    localparam logic [7:0] RESET_VEC = 8'hFF;
`ifdef PC_CTRL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       enable  = 1'b0;
    logic       load    = 1'b0;
    logic       branch  = 1'b0;
    logic       call    = 1'b0;
    logic       ret     = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] nxt_adr = 8'h00;
    logic [7:0] offset  = 8'h00;
    logic [7:0] crnt_adr;
    logic [1:0] sp_level;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;

    always #5 clk = ~clk;

    pc_ctrl #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .nxt_adr   (nxt_adr),
        .offset    (offset),
        .crnt_adr  (crnt_adr),
        .sp_level  (sp_level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},  32'(crnt_adr),  32'(m_pc));
        check({tag, ".sp"},  32'(sp_level),  32'(m_stk.size()));
        check({tag, ".ovf"}, 32'(overflow),  32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc  = RESET_VEC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic drive(input logic l, input logic c, input logic r, input logic b,
                         input logic e, input logic clr, input logic [7:0] n, input logic [7:0] o);
        load = l; call = c; ret = r; branch = b; enable = e; clr_err = clr;
        nxt_adr = n; offset = o;
    endtask

    // Reference behaviour from the current inputs, applied once per rising edge
    task automatic model_edge();
        logic [7:0] nxt_pc;
        logic       set_o;
        logic       set_u;
        nxt_pc = m_pc;
        set_o  = 1'b0;
        set_u  = 1'b0;
        if (load) begin
            nxt_pc = nxt_adr;
        end else if (call) begin
            if (!STACK_EN) begin
                nxt_pc = nxt_adr;
            end else if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 8'd1);
                nxt_pc = nxt_adr;
            end else begin
                set_o = 1'b1;
            end
        end else if (ret && STACK_EN) begin
            if (m_stk.size() > 0) nxt_pc = m_stk.pop_back();
            else                  set_u = 1'b1;
        end else if (branch) begin
            nxt_pc = m_pc + offset;
        end else if (enable) begin
            nxt_pc = m_pc + 8'd1;
        end
        m_pc  = nxt_pc;
        m_ovf = set_o | (m_ovf & ~clr_err);
        m_unf = set_u | (m_unf & ~clr_err);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Pulses reset between edges and checks outputs before any clock edge arrives
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #23;
        check_all("reset");
        drive(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        reset = 1'b1;
        step("wrap");
        check("wrap.const", 32'(crnt_adr), 32'h00);

        drive(1, 0, 0, 0, 0, 0, 8'h10, 8'h00);
        step("load10");
        drive(0, 1, 0, 0, 0, 0, 8'h40, 8'h00);
        step("call40");
        drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        step("ret11");
`ifdef PC_CTRL_STACK_EN
        check("ret11.const", 32'(crnt_adr), 32'h11);
`else
        drive(0, 1, 0, 0, 0, 0, 8'h30, 8'h00);
        step("nostk_call");
        check("nostk_call.const", 32'(crnt_adr), 32'h30);
        drive(0, 0, 1, 0, 1, 0, 8'h00, 8'h00);
        step("nostk_ret_en");
        check("nostk_ret_en.const", 32'(crnt_adr), 32'h31);
`endif

        drive(0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
        step("call_a");
        drive(0, 1, 0, 0, 0, 0, 8'h50, 8'h00);
        step("call_b");
        drive(0, 1, 0, 0, 0, 0, 8'h60, 8'h00);
        step("call_full");
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step("ovf_sticky");
        drive(0, 1, 0, 0, 0, 1, 8'h70, 8'h00);
        step("ovf_clr_coincident");
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        step("ovf_clr");

        drive(1, 0, 0, 0, 0, 0, 8'h05, 8'h00);
        step("load05");
        drive(0, 0, 0, 1, 0, 0, 8'h00, 8'hFC);
        step("branch_neg");
        check("branch_neg.const", 32'(crnt_adr), 32'h01);
        drive(1, 1, 0, 0, 1, 0, 8'h80, 8'h00);
        step("load_prio");
        check("load_prio.const", 32'(crnt_adr), 32'h80);

        drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        step("pop1");
        step("pop2");
        step("ret_empty");
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step("unf_sticky");
        drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        step("unf_clr");
        drive(0, 1, 0, 0, 0, 0, 8'h90, 8'h00);
        step("chain1");
        drive(0, 1, 0, 0, 0, 0, 8'hA0, 8'h00);
        step("chain2");
        drive(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        async_reset("midchain_rst");
        check("midchain_rst.const", 32'(crnt_adr), 32'hFF);
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                  8'($urandom), 8'($urandom));
            step("rand");
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
